io_port_bank: RTL and testbench
===============================

# io_port_bank

Peripheral-side responder for the processor core's I/O port. It buffers data from external producers in per-channel input FIFOs and serves the core's `req_in`/`addr_in` reads on `io_in`. It captures core writes (`out_en`/`addr_out`/`data_out`) into per-channel output registers with valid/ready handshakes toward external consumers. It can optionally raise `itr` when input data arrives.

## Interface
- `NUBITS`, 32, data width; equals the core's `NUBITS`.
- `NUIOIN`, 8, number of input channels.
- `NUIOOU`, 8, number of output channels.
- `FDEPTH`, 4, entries per input FIFO; power of 2, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `io_in`  out  NUBITS  head of FIFO `addr_in` to the core.
- `addr_in`  in  AIW = max(1,$clog2(NUIOIN))  input channel select from the core.
- `req_in`  in  1  core read strobe; pops the selected FIFO.
- `data_out`  in  NUBITS  core write data.
- `addr_out`  in  AOW = max(1,$clog2(NUIOOU))  output channel select.
- `out_en`  in  1  core write strobe.
- `itr`  out  1  interrupt request to the core.
- `in_data`  in  NUIOIN*NUBITS  producer data; channel i is at `[i*NUBITS +: NUBITS]`.
- `in_valid`  in  NUIOIN  producer valid.
- `in_ready`  out  NUIOIN  FIFO not full.
- `out_data`  out  NUIOOU*NUBITS  output registers.
- `out_valid`  out  NUIOOU  output register holds unconsumed data.
- `out_ready`  in  NUIOOU  consumer accept.

## Operation
- **Input channel i:** synchronous FIFO, `FDEPTH` entries, with a count register of width $clog2(FDEPTH)+1.
  - `in_ready[i]` = count < FDEPTH. This is combinational from the registered count, with no dependence on the pop in the same cycle.
  - Push on `in_valid[i] & in_ready[i]`.
- **Core read path:**
  - `io_in` is combinational. It shows the head of FIFO `addr_in` if that FIFO is non-empty; otherwise it is 0.
  - If `addr_in` ≥ NUIOIN, `io_in` is 0.
  - Pop on `req_in` when the selected FIFO is non-empty.
  - `req_in` on an empty or out-of-range channel has no side effect.
- **Simultaneous push and pop on one channel:** both happen and the count is unchanged. On a full FIFO, `in_ready` is already low, so only the pop occurs.
- **Output channel j:**
  - `out_en` with `addr_out` = j loads `data_out` into `out_data[j]` and sets `out_valid[j]`.
  - `out_valid[j] & out_ready[j]` clears valid; data is held.
  - A write to a valid register overwrites it and valid stays 1; the older word is lost.
  - A write and a consumer accept in the same cycle: the new data is loaded and valid stays 1.
  - If `addr_out` ≥ NUIOOU, the write is ignored.
- **Interrupt:** `itr` is a registered one-cycle pulse on the rising edge of `any_ne`, where `any_ne` = OR over all channels of (count ≠ 0). `any_ne` is itself registered to detect that edge.

## Timing
- Reset values:
  - all counts, pointers and `out_data` = 0
  - `out_valid` = 0, `itr` = 0
  - `in_ready` = all 1, `io_in` = 0
- Reset asserted mid-operation discards all buffered data immediately. Outputs take their reset values asynchronously.
- Input latency:
  - A push at edge N makes the word visible on `io_in` after edge N, so the core can read it in cycle N+1.
  - A pop at edge N exposes the next entry after edge N.
- Output latency: `out_en` at edge N gives `out_valid`/`out_data` updated after edge N. A consumer accepting at edge N+1 clears valid after edge N+1.
- `itr`:
  - `any_ne` rises after edge N, and `itr` is high for the cycle after edge N+1.
  - `itr` never stays high for consecutive cycles.
- Throughput: one push per channel and one core pop per cycle; one core write and one consume per output channel per cycle.

## Configuration
- `IO_PORT_ITR_EN` defined: the interrupt logic is built as described above.
- `IO_PORT_ITR_EN` undefined: `itr` is tied to 0 and the edge-detect registers are removed.

## Structure
- Package `io_port_pkg` holds:
  - localparam functions for AIW/AOW (the max(1,clog2) rule);
  - default `FDEPTH`;
  - a channel-index typedef helper.
- Sub-module `io_fifo` is a single-channel synchronous FIFO exposing push/pop/head/count. It is generated NUIOIN times.
- The output registers are inline.

## Test plan
- Reset, then idle: `in_ready` = 8'hFF, `out_valid` = 0, `io_in` = 0, `itr` = 0.
- Push 32'h11, 32'h22 on channel 3; `addr_in` = 3:
  - `io_in` = 32'h11;
  - `req_in` → `io_in` = 32'h22;
  - second `req_in` → `io_in` = 0 and count 0.
- Push 4 words on channel 0 → `in_ready[0]` = 0. Same-cycle `in_valid` and `req_in` → one pop, no push, then `in_ready[0]` = 1.
- `out_en`, `addr_out` = 5, `data_out` = 32'hDEAD → `out_valid[5]` = 1. Rewrite 32'hBEEF while `out_ready[5]` = 1 in the same cycle → `out_data` = BEEF, valid stays 1.
- With `IO_PORT_ITR_EN`: first push into all-empty FIFOs → exactly one `itr` pulse two cycles after the push edge. A second push gives no pulse. Without the macro, `itr` stays 0.
- Reset asserted between the push and pop of channel 2 → count 0, `io_in` = 0 immediately.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared sizing helpers and defaults for the io_port_bank peripheral.
//   idx_w(n)   : select width for n channels, never narrower than 1 bit
//   FDEPTH_DEF : default entries per input FIFO
//   chan_idx_t : generic channel index type
package io_port_pkg;
   localparam int FDEPTH_DEF = 4;
   typedef logic [15:0] chan_idx_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: single-channel synchronous FIFO.
//   clk, rst   : clock, asynchronous active-high reset (pointers and count)
//   push, din  : write strobe and data (caller guarantees not full)
//   pop        : read strobe (caller guarantees not empty)
//   head       : word at the read pointer
//   count      : number of stored words
module io_fifo #(
   parameter int W = 32,
   parameter int D = 4,
   localparam int PW = $clog2(D),
   localparam int CW = $clog2(D) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [D];
   logic [PW-1:0] wr, rd;
   assign head = mem[rd];
   always_ff @(posedge clk)
      if (push) mem[wr] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: core I/O port responder with per-channel input FIFOs and output registers.
//   clk, rst                     : clock, asynchronous active-high reset
//   addr_in, req_in, io_in       : core read select, pop strobe, head of selected FIFO (0 if empty/out of range)
//   addr_out, data_out, out_en   : core write select, data, strobe
//   itr                          : one-cycle pulse when any FIFO goes from all-empty to non-empty
//   in_data, in_valid, in_ready  : producer side of the input FIFOs
//   out_data, out_valid, out_ready : consumer side of the output registers
//   Macro IO_PORT_ITR_EN builds the interrupt logic; otherwise itr is tied to 0.
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 8,
   parameter int NUIOOU = 8,
   parameter int FDEPTH = FDEPTH_DEF,
   localparam int AIW = idx_w(NUIOIN),
   localparam int AOW = idx_w(NUIOOU),
   localparam int CW  = $clog2(FDEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [NUBITS-1:0]        io_in,
   input  logic [AIW-1:0]           addr_in,
   input  logic                     req_in,
   input  logic [NUBITS-1:0]        data_out,
   input  logic [AOW-1:0]           addr_out,
   input  logic                     out_en,
   output logic                     itr,
   input  logic [NUIOIN*NUBITS-1:0] in_data,
   input  logic [NUIOIN-1:0]        in_valid,
   output logic [NUIOIN-1:0]        in_ready,
   output logic [NUIOOU*NUBITS-1:0] out_data,
   output logic [NUIOOU-1:0]        out_valid,
   input  logic [NUIOOU-1:0]        out_ready
);
   logic [NUIOIN-1:0][NUBITS-1:0] heads;
   logic [CW-1:0]                 cnt [NUIOIN];
   logic [NUIOIN-1:0]             ne, push, pop;

   for (genvar i = 0; i < NUIOIN; i++) begin : g_in
      assign ne[i]       = cnt[i] != '0;
      assign in_ready[i] = cnt[i] < CW'(FDEPTH);
      assign push[i]     = in_valid[i] & in_ready[i];
      io_fifo #(.W(NUBITS), .D(FDEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   (in_data[i*NUBITS +: NUBITS]),
         .head  (heads[i]),
         .count (cnt[i])
      );
   end

   // Address decode by comparison so an out-of-range addr_in simply matches nothing.
   always_comb begin
      io_in = '0;
      pop   = '0;
      for (int i = 0; i < NUIOIN; i++)
         if (addr_in == AIW'(i) && ne[i]) begin
            io_in  = heads[i];
            pop[i] = req_in;
         end
   end

   // A core write wins over a same-cycle consumer accept: new data stays valid.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_data  <= '0;
         out_valid <= '0;
      end else
         for (int j = 0; j < NUIOOU; j++)
            if (out_en && addr_out == AOW'(j)) begin
               out_data[j*NUBITS +: NUBITS] <= data_out;
               out_valid[j]                 <= 1'b1;
            end else if (out_ready[j])
               out_valid[j] <= 1'b0;

`ifdef IO_PORT_ITR_EN
   logic any_ne, any_ne_q;
   assign any_ne = |ne;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         any_ne_q <= 1'b0;
         itr      <= 1'b0;
      end else begin
         any_ne_q <= any_ne;
         itr      <= any_ne & ~any_ne_q;
      end
`else
   assign itr = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed self-checking bench for io_port_bank.
module tb_io_port_bank;
   localparam int NB = 32;
`ifdef IO_PORT_ITR_EN
   localparam bit ITR = 1'b1;
`else
   localparam bit ITR = 1'b0;
`endif
   logic            clk = 1'b0, rst = 1'b1;
   logic [NB-1:0]   io_in, data_out = '0;
   logic [2:0]      addr_in = '0, addr_out = '0;
   logic            req_in = 1'b0, out_en = 1'b0, itr;
   logic [8*NB-1:0] in_data = '0, out_data;
   logic [7:0]      in_valid = '0, in_ready, out_valid, out_ready = '0;
   int              n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   io_port_bank dut (
      .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
      .data_out(data_out), .addr_out(addr_out), .out_en(out_en), .itr(itr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'hFF);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_io_in", 64'(io_in), 64'h0);
      chk("rst_itr", 64'(itr), 64'h0);

      addr_in = 3'd3;
      in_data[3*NB +: NB] = 32'h11;
      in_valid = 8'h08;
      step();
      chk("ch3_head", 64'(io_in), 64'h11);
      chk("itr_edge_n", 64'(itr), 64'h0);
      in_data[3*NB +: NB] = 32'h22;
      step();
      chk("itr_pulse", 64'(itr), 64'(ITR));
      in_valid = '0;
      step();
      chk("itr_one_cycle", 64'(itr), 64'h0);
      chk("ch3_still_head", 64'(io_in), 64'h11);
      req_in = 1'b1;
      step();
      chk("ch3_pop1", 64'(io_in), 64'h22);
      step();
      req_in = 1'b0;
      chk("ch3_pop2", 64'(io_in), 64'h0);
      chk("ch3_ready", 64'(in_ready), 64'hFF);
      step();
      chk("ch3_empty_req", 64'(io_in), 64'h0);

      addr_in = 3'd0;
      in_valid = 8'h01;
      for (int k = 0; k < 4; k++) begin
         in_data[0 +: NB] = 32'hA0 + 32'(k);
         step();
         chk($sformatf("itr_fill%0d", k), 64'(itr), 64'((k == 1) ? ITR : 1'b0));
      end
      chk("ch0_full", 64'(in_ready), 64'hFE);
      chk("ch0_head", 64'(io_in), 64'hA0);
      in_data[0 +: NB] = 32'hA4;
      req_in = 1'b1;
      step();
      in_valid = '0;
      chk("ch0_full_pop_ready", 64'(in_ready), 64'hFF);
      chk("ch0_full_pop_head", 64'(io_in), 64'hA1);
      chk("itr_quiet", 64'(itr), 64'h0);
      step();
      chk("ch0_drain2", 64'(io_in), 64'hA2);
      step();
      chk("ch0_drain3", 64'(io_in), 64'hA3);
      step();
      req_in = 1'b0;
      chk("ch0_drained", 64'(io_in), 64'h0);

      out_en = 1'b1;
      addr_out = 3'd5;
      data_out = 32'hDEAD;
      step();
      chk("out5_valid", 64'(out_valid), 64'h20);
      chk("out5_dead", 64'(out_data[5*NB +: NB]), 64'hDEAD);
      data_out = 32'hBEEF;
      out_ready = 8'h20;
      step();
      out_en = 1'b0;
      chk("out5_rewrite_valid", 64'(out_valid), 64'h20);
      chk("out5_beef", 64'(out_data[5*NB +: NB]), 64'hBEEF);
      step();
      out_ready = '0;
      chk("out5_consumed", 64'(out_valid), 64'h0);
      chk("out5_held", 64'(out_data[5*NB +: NB]), 64'hBEEF);
      out_en = 1'b1;
      addr_out = 3'd2;
      data_out = 32'h1234;
      step();
      out_en = 1'b0;
      step();
      chk("out2_valid_held", 64'(out_valid), 64'h04);
      chk("out2_data", 64'(out_data[2*NB +: NB]), 64'h1234);

      addr_in = 3'd2;
      in_data[2*NB +: NB] = 32'h77;
      in_valid = 8'h04;
      step();
      in_valid = '0;
      chk("ch2_head", 64'(io_in), 64'h77);
      #2 rst = 1'b1;
      #1;
      chk("arst_io_in", 64'(io_in), 64'h0);
      chk("arst_in_ready", 64'(in_ready), 64'hFF);
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_out_data", 64'(out_data[2*NB +: NB]), 64'h0);
      chk("arst_itr", 64'(itr), 64'h0);
      step();
      rst = 1'b0;
      req_in = 1'b1;
      step();
      req_in = 1'b0;
      chk("post_rst_io_in", 64'(io_in), 64'h0);
      chk("post_rst_ready", 64'(in_ready), 64'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
